trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences machine-mode trap entry and MRET for the single-cycle core using the CSR file's single write port.
//  Detects sync exceptions (illegal, ecall) and async interrupts (ext, timer) at instruction boundaries.
//  Stalls the core, then issues one CSR write per cycle (mepc, mcause, mstatus) and a PC redirect.
//  Sits between decode/retire logic, the CSR register file and the PC mux.
// PARAMETERS
//  SYNC_STAGES  2  flop stages on irq_ext_i / irq_timer_i (min 1)
//  VECTORED_EN  1  1: honour mtvec MODE=1 for interrupts; 0: always direct
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  pc_i           in   32  PC of instruction in execute this cycle
//  retire_i       in   1   instruction at pc_i completes this cycle
//  illegal_i      in   1   instruction at pc_i is illegal (valid with retire_i)
//  ecall_i        in   1   instruction at pc_i is ECALL (valid with retire_i)
//  mret_i         in   1   instruction at pc_i is MRET (valid with retire_i)
//  irq_ext_i      in   1   external interrupt, level, async
//  irq_timer_i    in   1   timer interrupt, level, async
//  mstatus_i      in   32  current mstatus from CSR file
//  mie_i          in   32  current mie
//  mtvec_i        in   32  current mtvec
//  mepc_i         in   32  current mepc
//  mip_o          out  32  pending: bit7=timer sync, bit11=ext sync, others 0
//  csr_we_o       out  1   CSR write strobe (one cycle per write)
//  csr_addr_o     out  12  CSR write address
//  csr_wdata_o    out  32  CSR write data
//  stall_o        out  1   hold PC, suppress core regfile/CSR writes
//  redirect_o     out  1   one-cycle pulse: load redirect_pc_o into PC
//  redirect_pc_o  out  32  redirect target
// BEHAVIOUR
//  Reset: state IDLE; sync flops, mip_o, csr_we_o, stall_o, redirect_o = 0; addr/wdata/redirect_pc = 0.
//  rst mid-sequence aborts to IDLE; no further CSR writes/redirect issued.
//  States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, R_STATUS, R_REDIR. stall_o = (state != IDLE).
//  IDLE detection (only when retire_i=1), priority high->low:
//   illegal_i: cause=2, epc=pc_i.  ecall_i: cause=11, epc=pc_i.
//   ext irq (mstatus_i[3] & mie_i[11] & mip_o[11]): cause=32'h8000_000B, epc=pc_i+4 (mod 2^32).
//   timer irq (mstatus_i[3] & mie_i[7] & mip_o[7]): cause=32'h8000_0007, epc=pc_i+4.
//   mret_i: -> R_STATUS.  Any trap -> T_EPC. cause, epc, mstatus_i, mtvec_i latched at detection.
//  Core must suppress writeback of an excepting instruction in detection cycle (stall_o is 0 then).
//  T_EPC:    we=1, addr=12'h341, wdata=epc            -> T_CAUSE
//  T_CAUSE:  we=1, addr=12'h342, wdata=cause          -> T_STATUS
//  T_STATUS: we=1, addr=12'h300, wdata=mstatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11 -> T_REDIR
//  T_REDIR:  redirect_o=1; pc = {mtvec[31:2],2'b00} + (VECTORED_EN & mtvec[1:0]==1 & cause[31] ? cause[4:0]<<2 : 0) -> IDLE
//  mtvec MODE 2/3 treated as direct. Trap latency: detection T, redirect at T+4.
//  R_STATUS: we=1, addr=12'h300, wdata=mstatus_i with MIE[3]=MPIE[7], MPIE[7]=1 -> R_REDIR
//  R_REDIR:  redirect_o=1, redirect_pc_o=mepc_i -> IDLE. MRET latency: redirect at T+2.
//  Inputs other than irq ignored outside IDLE; irqs are levels, stay pending, re-evaluated on return to IDLE.
//  Interrupts never taken when retire_i=0; first boundary after redirect may take a new trap.
//  csr_we_o high exactly one cycle per listed write; never asserted in IDLE or *_REDIR.
// TESTING
//  illegal_i+retire_i at pc=0x100, mtvec=0x200 -> writes 341=0x100, 342=2, 300 MIE cleared; redirect 0x200 at T+4.
//  ext irq, mstatus=0x8, mie=0x800, mtvec=0x401, pc=0x40 -> mepc=0x44, mcause=0x8000000B, redirect 0x42C.
//  ext+timer pending, both enabled -> ext taken first; after MRET (mepc restored), timer taken next boundary.
//  irq pending with mstatus[3]=0 or retire_i=0 -> no stall, no CSR writes, mip_o reflects pending after SYNC_STAGES.
//  MRET with mstatus=0x80, mepc=0x300 -> write 300=0x88, redirect 0x300 at T+2.
//  rst asserted in T_CAUSE -> next cycle IDLE, stall_o=0, no mstatus write, no redirect.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer. Stalls the core while it issues
// one CSR write per cycle through the CSR file's single write port, then
// pulses a PC redirect. Interrupt levels are synchronised before use.
module trap_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        retire_i,
   input  logic        illegal_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        irq_ext_i,
   input  logic        irq_timer_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic [31:0] mip_o,
   output logic        csr_we_o,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_wdata_o,
   output logic        stall_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_EPC    = 3'd1,
      T_CAUSE  = 3'd2,
      T_STATUS = 3'd3,
      T_REDIR  = 3'd4,
      R_STATUS = 3'd5,
      R_REDIR  = 3'd6
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
   logic [SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;
   logic [31:0]            cause_q, cause_d;
   logic [31:0]            epc_q, epc_d;
   logic [31:0]            mstatus_q, mstatus_d;
   logic [31:0]            mtvec_q, mtvec_d;

   logic        ext_take, tmr_take;
   logic [31:0] trap_status, mret_status, vec_off, trap_pc;

   // Only bits 7 and 11 of mie take part in the decision.
   logic unused_mie;
   assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0]};

   // Pending bits are the last synchroniser stage of each interrupt line.
   assign mip_o = {20'd0, ext_sync_q[SYNC_STAGES-1], 3'd0, tmr_sync_q[SYNC_STAGES-1], 7'd0};

   assign ext_take = mstatus_i[3] & mie_i[11] & mip_o[11];
   assign tmr_take = mstatus_i[3] & mie_i[7] & mip_o[7];

   // Shift the asynchronous interrupt levels through the synchroniser chain.
   always_comb begin
      ext_sync_d    = '0;
      tmr_sync_d    = '0;
      ext_sync_d[0] = irq_ext_i;
      tmr_sync_d[0] = irq_timer_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         ext_sync_d[i] = ext_sync_q[i-1];
         tmr_sync_d[i] = tmr_sync_q[i-1];
      end
   end

   // State register plus the trap context captured at detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ext_sync_q <= '0;
         tmr_sync_q <= '0;
         cause_q    <= '0;
         epc_q      <= '0;
         mstatus_q  <= '0;
         mtvec_q    <= '0;
      end else begin
         state_q    <= state_d;
         ext_sync_q <= ext_sync_d;
         tmr_sync_q <= tmr_sync_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         mstatus_q  <= mstatus_d;
         mtvec_q    <= mtvec_d;
      end
   end

   // Next state: prioritised detection at a retiring boundary, then fixed walk.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      case (state_q)
         IDLE: begin
            if (retire_i) begin
               if (illegal_i) begin
                  cause_d = 32'd2;
                  epc_d   = pc_i;
                  state_d = T_EPC;
               end else if (ecall_i) begin
                  cause_d = 32'd11;
                  epc_d   = pc_i;
                  state_d = T_EPC;
               end else if (ext_take) begin
                  cause_d = 32'h8000_000B;
                  epc_d   = pc_i + 32'd4;
                  state_d = T_EPC;
               end else if (tmr_take) begin
                  cause_d = 32'h8000_0007;
                  epc_d   = pc_i + 32'd4;
                  state_d = T_EPC;
               end else if (mret_i) begin
                  state_d = R_STATUS;
               end
               if (state_d == T_EPC) begin
                  mstatus_d = mstatus_i;
                  mtvec_d   = mtvec_i;
               end
            end
         end
         T_EPC:    state_d = T_CAUSE;
         T_CAUSE:  state_d = T_STATUS;
         T_STATUS: state_d = T_REDIR;
         T_REDIR:  state_d = IDLE;
         R_STATUS: state_d = R_REDIR;
         R_REDIR:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state: one CSR write or redirect per cycle.
   always_comb begin
      trap_status        = mstatus_q;
      trap_status[7]     = mstatus_q[3];
      trap_status[3]     = 1'b0;
      trap_status[12:11] = 2'b11;
      mret_status        = mstatus_i;
      mret_status[3]     = mstatus_i[7];
      mret_status[7]     = 1'b1;
      // MODE 2/3 fall back to direct; only interrupts use the vector table.
      vec_off = (VECTORED_EN && mtvec_q[1:0] == 2'b01 && cause_q[31]) ?
                {25'd0, cause_q[4:0], 2'b00} : 32'd0;
      trap_pc = {mtvec_q[31:2], 2'b00} + vec_off;

      csr_we_o      = 1'b0;
      csr_addr_o    = 12'd0;
      csr_wdata_o   = 32'd0;
      redirect_o    = 1'b0;
      redirect_pc_o = 32'd0;
      stall_o       = (state_q != IDLE);
      case (state_q)
         T_EPC: begin
            csr_we_o    = 1'b1;
            csr_addr_o  = ADDR_MEPC;
            csr_wdata_o = epc_q;
         end
         T_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_addr_o  = ADDR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         T_STATUS: begin
            csr_we_o    = 1'b1;
            csr_addr_o  = ADDR_MSTATUS;
            csr_wdata_o = trap_status;
         end
         T_REDIR: begin
            redirect_o    = 1'b1;
            redirect_pc_o = trap_pc;
         end
         R_STATUS: begin
            csr_we_o    = 1'b1;
            csr_addr_o  = ADDR_MSTATUS;
            csr_wdata_o = mret_status;
         end
         R_REDIR: begin
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a CSR-file mirror and an event-level model predict
// every CSR write / redirect with its cycle; a negedge monitor checks them.
module tb_trap_sequencer;

   localparam int S  = 2;
   localparam int EW = 77;  // {is_redirect, addr[11:0], data[31:0], cycle[31:0]}

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = '0;
   logic        retire_i = 0, illegal_i = 0, ecall_i = 0, mret_i = 0;
   logic        irq_ext_i = 0, irq_timer_i = 0;
   logic [31:0] mstatus_i = '0, mie_i = '0, mtvec_i = '0, mepc_i = '0;
   logic [31:0] mip_o;
   logic        csr_we_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_wdata_o;
   logic        stall_o, redirect_o;
   logic [31:0] redirect_pc_o;

   always #5 clk = ~clk;

   trap_sequencer #(.SYNC_STAGES(S), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .retire_i(retire_i),
      .illegal_i(illegal_i), .ecall_i(ecall_i), .mret_i(mret_i),
      .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
      .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .mip_o(mip_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
      .csr_wdata_o(csr_wdata_o), .stall_o(stall_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o)
   );

   // ---------------- model state ----------------
   typedef struct { int cy; logic [11:0] a; logic [31:0] d; } wr_t;

   logic [EW-1:0] exp_q[$];
   wr_t           pend_q[$];
   logic [31:0]   m_mstatus = '0, m_mie = '0, m_mtvec = '0, m_mepc = '0;
   bit            ext_hist [0:16383];
   bit            tmr_hist [0:16383];
   bit            ext_lvl = 0, tmr_lvl = 0;
   int            cyc = 0, busy_until = 0, stall_lo = 0, rst_release = 0;
   int            n_vec = 0, n_err = 0;

   function automatic int ev_cyc(logic [EW-1:0] e);
      return int'(e[31:0]);
   endfunction

   // Pending level seen by the core: the line as driven S cycles earlier,
   // but nothing sampled at or before the last reset cycle.
   function automatic bit pend(int c, bit is_ext);
      if (c - S < rst_release) return 1'b0;
      return is_ext ? ext_hist[c-S] : tmr_hist[c-S];
   endfunction

   task automatic push_ev(bit is_redir, logic [11:0] a, logic [31:0] d, int cy);
      wr_t w;
      exp_q.push_back({is_redir, a, d, 32'(cy)});
      if (!is_redir) begin
         w.cy = cy; w.a = a; w.d = d;
         pend_q.push_back(w);
      end
   endtask

   task automatic take_trap(int c, logic [31:0] cause, logic [31:0] epc);
      logic [31:0] st, tgt;
      st = m_mstatus;
      st[7] = m_mstatus[3];
      st[3] = 1'b0;
      st[12:11] = 2'b11;
      tgt = {m_mtvec[31:2], 2'b00};
      if (m_mtvec[1:0] == 2'd1 && cause[31]) tgt = tgt + 32'(cause[4:0]) * 32'd4;
      push_ev(1'b0, 12'h341, epc, c + 1);
      push_ev(1'b0, 12'h342, cause, c + 2);
      push_ev(1'b0, 12'h300, st, c + 3);
      push_ev(1'b1, 12'h000, tgt, c + 4);
      stall_lo = c + 1;
      busy_until = c + 5;
   endtask

   task automatic model_step(int c);
      logic [31:0] st;
      if (c < busy_until || !retire_i) return;
      if (illegal_i)                                        take_trap(c, 32'd2, pc_i);
      else if (ecall_i)                                     take_trap(c, 32'd11, pc_i);
      else if (m_mstatus[3] && m_mie[11] && pend(c, 1'b1))  take_trap(c, 32'h8000_000B, pc_i + 32'd4);
      else if (m_mstatus[3] && m_mie[7] && pend(c, 1'b0))   take_trap(c, 32'h8000_0007, pc_i + 32'd4);
      else if (mret_i) begin
         st = m_mstatus;
         st[3] = m_mstatus[7];
         st[7] = 1'b1;
         push_ev(1'b0, 12'h300, st, c + 1);
         push_ev(1'b1, 12'h000, m_mepc, c + 2);
         stall_lo = c + 1;
         busy_until = c + 3;
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(bit r, bit ret, bit ill, bit ec, bit mr, logic [31:0] pc);
      @(posedge clk);
      cyc++;
      #1;
      if (r) begin
         while (exp_q.size() > 0 && ev_cyc(exp_q[$]) >= cyc) void'(exp_q.pop_back());
         while (pend_q.size() > 0 && pend_q[$].cy >= cyc) void'(pend_q.pop_back());
         busy_until = 0;
         stall_lo = 0;
         rst_release = cyc + 1;
      end
      // CSR file commits a write at the edge ending its cycle.
      while (pend_q.size() > 0 && pend_q[0].cy < cyc) begin
         case (pend_q[0].a)
            12'h300: m_mstatus = pend_q[0].d;
            12'h341: m_mepc = pend_q[0].d;
            default: ;
         endcase
         void'(pend_q.pop_front());
      end
      rst = r;
      retire_i = ret; illegal_i = ill; ecall_i = ec; mret_i = mr; pc_i = pc;
      irq_ext_i = ext_lvl; irq_timer_i = tmr_lvl;
      mstatus_i = m_mstatus; mie_i = m_mie; mtvec_i = m_mtvec; mepc_i = m_mepc;
      ext_hist[cyc] = ext_lvl;
      tmr_hist[cyc] = tmr_lvl;
      if (!r) model_step(cyc);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic [31:0]   exp_mip;
      bit            exp_stall;
      if (!rst) begin
         while (exp_q.size() > 0 && ev_cyc(exp_q[0]) < cyc) begin
            n_vec++; n_err++;
            $display("FAIL missing_event cyc=%0d: got nothing, required %h", cyc, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (csr_we_o || redirect_o) begin
            n_vec++;
            if (csr_we_o && redirect_o) begin
               n_err++;
               $display("FAIL we_and_redirect cyc=%0d: got both, required at most one", cyc);
            end else if (exp_q.size() == 0 || ev_cyc(exp_q[0]) != cyc) begin
               n_err++;
               $display("FAIL unexpected_event cyc=%0d: got we=%0b addr=%h wdata=%h redir=%0b pc=%h, required none",
                        cyc, csr_we_o, csr_addr_o, csr_wdata_o, redirect_o, redirect_pc_o);
            end else begin
               e = exp_q.pop_front();
               if (e[76] != redirect_o) begin
                  n_err++;
                  $display("FAIL event_kind cyc=%0d: got redirect=%0b, required %0b", cyc, redirect_o, e[76]);
               end else if (redirect_o && redirect_pc_o != e[63:32]) begin
                  n_err++;
                  $display("FAIL redirect_pc cyc=%0d: got %h, required %h", cyc, redirect_pc_o, e[63:32]);
               end else if (csr_we_o && (csr_addr_o != e[75:64] || csr_wdata_o != e[63:32])) begin
                  n_err++;
                  $display("FAIL csr_write cyc=%0d: got %h=%h, required %h=%h",
                           cyc, csr_addr_o, csr_wdata_o, e[75:64], e[63:32]);
               end
            end
         end
         exp_stall = (cyc >= stall_lo) && (cyc < busy_until);
         n_vec++;
         if (stall_o !== exp_stall) begin
            n_err++;
            $display("FAIL stall cyc=%0d: got %b, required %b", cyc, stall_o, exp_stall);
         end
         exp_mip = {20'd0, pend(cyc, 1'b1), 3'd0, pend(cyc, 1'b0), 7'd0};
         n_vec++;
         if (mip_o !== exp_mip) begin
            n_err++;
            $display("FAIL mip cyc=%0d: got %h, required %h", cyc, mip_o, exp_mip);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit r_ill, r_ec, r_mr;
      int k;
      logic [31:0] r_pc;

      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(2);

      // Illegal instruction, direct mtvec.
      m_mstatus = 32'h8; m_mtvec = 32'h200; m_mie = 32'h0;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
      idle(6);

      // External interrupt with vectored mtvec; retire_i=0 while pending first.
      m_mstatus = 32'h8; m_mie = 32'h800; m_mtvec = 32'h401;
      ext_lvl = 1;
      idle(4);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
      ext_lvl = 0;
      idle(6);

      // Both pending: ext first, then MRET, then timer at the next boundary.
      m_mstatus = 32'h8; m_mie = 32'h880; m_mtvec = 32'h401;
      ext_lvl = 1; tmr_lvl = 1;
      idle(3);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
      ext_lvl = 0;
      idle(6);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
      idle(2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h84);
      tmr_lvl = 0;
      idle(6);

      // Pending interrupt masked by mstatus.MIE: no trap at retiring boundaries.
      m_mstatus = 32'h0; m_mie = 32'h880; ext_lvl = 1; tmr_lvl = 1;
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i * 4));
      ext_lvl = 0; tmr_lvl = 0;
      idle(4);

      // MRET.
      m_mstatus = 32'h80; m_mepc = 32'h300;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600);
      idle(4);

      // Reset while writing mcause aborts the rest of the sequence.
      m_mstatus = 32'h8; m_mtvec = 32'h700;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
      idle(1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(6);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         end else begin
            if (cyc + 1 >= busy_until && $urandom_range(0, 4) == 0) begin
               m_mstatus = $urandom();
               m_mie = $urandom();
               m_mtvec = $urandom();
               m_mepc = $urandom() & 32'hFFFF_FFFC;
            end
            if ($urandom_range(0, 19) == 0) ext_lvl = ~ext_lvl;
            if ($urandom_range(0, 19) == 0) tmr_lvl = ~tmr_lvl;
            k = $urandom_range(0, 19);
            r_ill = (k < 3);
            r_ec  = (k >= 2 && k < 5);
            r_mr  = (k >= 4 && k < 8);
            r_pc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            drive(1'b0, ($urandom_range(0, 9) < 7), r_ill, r_ec, r_mr, r_pc);
         end
      end
      idle(8);

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d events outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
